// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register and write-back stage of the LEGv8 core.
// It captures the MEM-stage result, then sizes and extends load data.
// It drives the register-file write port and suppresses writes to X31 (XZR).
// It also counts retired instructions.
// Optional feature macro: WB_BYPASS_EN adds a same-cycle write->read bypass
// for the two ID-stage read ports.
`ifndef WORD
`define WORD 64
`endif

module wb_stage #(
    parameter int WORD_W = `WORD,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m_valid,
    input  logic              m_RegWrite,
    input  logic              m_MemtoReg,
    input  logic [1:0]        m_size,
    input  logic              m_signed,
    input  logic [4:0]        m_rd,
    input  logic [WORD_W-1:0] m_alu_res,
    input  logic [WORD_W-1:0] m_mem_rdata,
    input  logic              stall,
    input  logic              flush,
`ifdef WB_BYPASS_EN
    input  logic [4:0]        r_reg1,
    input  logic [4:0]        r_reg2,
    input  logic [WORD_W-1:0] r_data1,
    input  logic [WORD_W-1:0] r_data2,
    output logic [WORD_W-1:0] byp_data1,
    output logic [WORD_W-1:0] byp_data2,
    output logic              byp_hit1,
    output logic              byp_hit2,
`endif
    output logic [4:0]        w_reg,
    output logic [WORD_W-1:0] w_data,
    output logic              RegWrite,
    output logic [CNT_W-1:0]  retired
);

    localparam logic [4:0] XZR = 5'd31;

    // Take the low byte/half/word/double of the right-aligned load data.
    // Then zero- or sign-extend it; a double load ignores the signed flag.
    function automatic logic [WORD_W-1:0] load_ext(
        input logic [WORD_W-1:0] rdata,
        input logic [1:0]        size,
        input logic              sgn
    );
        logic [WORD_W-1:0] ext;
        case (size)
            2'b00: ext = {{(WORD_W-8){sgn & rdata[7]}}, rdata[7:0]};
            2'b01: ext = {{(WORD_W-16){sgn & rdata[15]}}, rdata[15:0]};
            2'b10: ext = {{(WORD_W-32){sgn & rdata[31]}}, rdata[31:0]};
            2'b11: ext = rdata;
            default: ext = rdata;
        endcase
        return ext;
    endfunction

    logic              wb_valid_r;
    logic              wb_we_r;
    logic [4:0]        wb_rd_r;
    logic [WORD_W-1:0] wb_data_r;
    logic [CNT_W-1:0]  retired_r;
    logic [WORD_W-1:0] result_s;
    logic              capture_s;

    // Choose the write-back value: the ALU result or the extended load data.
    always_comb begin
        result_s = m_alu_res;
        if (m_MemtoReg) begin
            result_s = load_ext(m_mem_rdata, m_size, m_signed);
        end else begin
            result_s = m_alu_res;
        end
    end

    assign capture_s = m_valid & ~flush & ~stall;

    // MEM/WB register: capture when not stalled; flush still kills valid during a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_r <= 1'b0;
            wb_we_r    <= 1'b0;
            wb_rd_r    <= 5'd0;
            wb_data_r  <= {WORD_W{1'b0}};
        end else if (!stall) begin
            wb_valid_r <= m_valid & ~flush;
            wb_we_r    <= m_RegWrite;
            wb_rd_r    <= m_rd;
            wb_data_r  <= result_s;
        end else if (flush) begin
            wb_valid_r <= 1'b0;
        end else begin
            wb_valid_r <= wb_valid_r;
        end
    end

    // Retire counter: one count per valid instruction captured; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_r <= {CNT_W{1'b0}};
        end else if (capture_s) begin
            retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            retired_r <= retired_r;
        end
    end

    // The write enable is derived from registered state only.
    // An asynchronous reset therefore drops it at once.
    assign w_reg    = wb_rd_r;
    assign w_data   = wb_data_r;
    assign RegWrite = wb_valid_r & wb_we_r & (wb_rd_r != XZR);
    assign retired  = retired_r;

`ifdef WB_BYPASS_EN
    // Same-cycle bypass: forward the pending write to a matching ID read.
    // X31 never hits because RegWrite is already low for it.
    always_comb begin
        byp_hit1  = RegWrite & (r_reg1 == wb_rd_r);
        byp_hit2  = RegWrite & (r_reg2 == wb_rd_r);
        byp_data1 = r_data1;
        byp_data2 = r_data2;
        if (byp_hit1) begin
            byp_data1 = wb_data_r;
        end else begin
            byp_data1 = r_data1;
        end
        if (byp_hit2) begin
            byp_data2 = wb_data_r;
        end else begin
            byp_data2 = r_data2;
        end
    end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage.
// It uses a table of vectors plus hand-written stall/flush, reset and bypass sequences.
// Expected results are queued when stimulus is driven and compared after the capture edge.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m_valid, m_RegWrite, m_MemtoReg, m_signed, stall, flush;
    logic [1:0]  m_size;
    logic [4:0]  m_rd;
    logic [63:0] m_alu_res, m_mem_rdata;
    logic [4:0]  w_reg;
    logic [63:0] w_data;
    logic        RegWrite;
    logic [31:0] retired;
`ifdef WB_BYPASS_EN
    logic [4:0]  r_reg1, r_reg2;
    logic [63:0] r_data1, r_data2, byp_data1, byp_data2;
    logic        byp_hit1, byp_hit2;
`endif

    always #5 clk = ~clk;

    wb_stage #(.WORD_W(64), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_valid(m_valid), .m_RegWrite(m_RegWrite), .m_MemtoReg(m_MemtoReg),
        .m_size(m_size), .m_signed(m_signed), .m_rd(m_rd),
        .m_alu_res(m_alu_res), .m_mem_rdata(m_mem_rdata),
        .stall(stall), .flush(flush),
`ifdef WB_BYPASS_EN
        .r_reg1(r_reg1), .r_reg2(r_reg2), .r_data1(r_data1), .r_data2(r_data2),
        .byp_data1(byp_data1), .byp_data2(byp_data2),
        .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
`endif
        .w_reg(w_reg), .w_data(w_data), .RegWrite(RegWrite), .retired(retired)
    );

    typedef struct {
        logic        valid, rw, m2r;
        logic [1:0]  size;
        logic        sgn;
        logic [4:0]  rd;
        logic [63:0] alu, rdata;
        logic        stl, fl;
        logic        e_we;
        logic [4:0]  e_reg;
        logic [63:0] e_data;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  rg;
        logic [63:0] data;
        logic [31:0] ret;
    } exp_t;

    exp_t        sb_q[$];
    vec_t        tbl[11];
    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [31:0] model_ret = 32'd0;

    localparam logic [63:0] LD = 64'hFFFF_FFFF_8000_0080;

    function automatic vec_t mk(logic valid, logic rw, logic m2r, logic [1:0] size, logic sgn,
                                logic [4:0] rd, logic [63:0] alu, logic stl, logic fl,
                                logic e_we, logic [4:0] e_reg, logic [63:0] e_data);
        vec_t v;
        v.valid = valid; v.rw = rw; v.m2r = m2r; v.size = size; v.sgn = sgn;
        v.rd = rd; v.alu = alu; v.rdata = LD; v.stl = stl; v.fl = fl;
        v.e_we = e_we; v.e_reg = e_reg; v.e_data = e_data;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        total_cnt++;
        if (act === expv) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, expv);
    endtask

    // Drive one vector, queue its expected result, then compare after the capture edge.
    task automatic apply(input vec_t v, input string nm);
        exp_t e;
        m_valid = v.valid; m_RegWrite = v.rw; m_MemtoReg = v.m2r; m_size = v.size;
        m_signed = v.sgn; m_rd = v.rd; m_alu_res = v.alu; m_mem_rdata = v.rdata;
        stall = v.stl; flush = v.fl;
        if (v.valid && !v.fl && !v.stl) model_ret = model_ret + 32'd1;
        e.we = v.e_we; e.rg = v.e_reg; e.data = v.e_data; e.ret = model_ret;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk({nm, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            chk({nm, "_RegWrite"}, {63'd0, RegWrite}, {63'd0, e.we});
            chk({nm, "_w_reg"}, {59'd0, w_reg}, {59'd0, e.rg});
            chk({nm, "_w_data"}, w_data, e.data);
            chk({nm, "_retired"}, {32'd0, retired}, {32'd0, e.ret});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        m_valid = 1'b0; m_RegWrite = 1'b0; m_MemtoReg = 1'b0; m_size = 2'b00;
        m_signed = 1'b0; m_rd = 5'd0; m_alu_res = 64'd0; m_mem_rdata = 64'd0;
        stall = 1'b0; flush = 1'b0;
`ifdef WB_BYPASS_EN
        r_reg1 = 5'd0; r_reg2 = 5'd0; r_data1 = 64'd0; r_data2 = 64'd0;
`endif
        //           val  rw   m2r  size   sgn  rd     alu              stl  fl   we   reg    data
        tbl[0]  = mk(1'b1,1'b1,1'b0,2'b00,1'b0,5'd5, 64'h1234,        1'b0,1'b0,1'b1,5'd5, 64'h1234);
        tbl[1]  = mk(1'b1,1'b1,1'b1,2'b00,1'b0,5'd1, 64'h0,           1'b0,1'b0,1'b1,5'd1, 64'h80);
        tbl[2]  = mk(1'b1,1'b1,1'b1,2'b00,1'b1,5'd2, 64'h0,           1'b0,1'b0,1'b1,5'd2, 64'hFFFF_FFFF_FFFF_FF80);
        tbl[3]  = mk(1'b1,1'b1,1'b1,2'b10,1'b1,5'd3, 64'h0,           1'b0,1'b0,1'b1,5'd3, 64'hFFFF_FFFF_8000_0080);
        tbl[4]  = mk(1'b1,1'b1,1'b1,2'b01,1'b0,5'd4, 64'h0,           1'b0,1'b0,1'b1,5'd4, 64'h0080);
        tbl[5]  = mk(1'b1,1'b1,1'b1,2'b01,1'b1,5'd6, 64'h0,           1'b0,1'b0,1'b1,5'd6, 64'h0080);
        tbl[6]  = mk(1'b1,1'b1,1'b1,2'b10,1'b0,5'd8, 64'h0,           1'b0,1'b0,1'b1,5'd8, 64'h8000_0080);
        tbl[7]  = mk(1'b1,1'b1,1'b1,2'b11,1'b1,5'd9, 64'h0,           1'b0,1'b0,1'b1,5'd9, LD);
        tbl[8]  = mk(1'b1,1'b1,1'b0,2'b00,1'b0,5'd31,64'h55,          1'b0,1'b0,1'b0,5'd31,64'h55);
        tbl[9]  = mk(1'b0,1'b1,1'b0,2'b00,1'b0,5'd10,64'h66,          1'b0,1'b0,1'b0,5'd10,64'h66);
        tbl[10] = mk(1'b1,1'b0,1'b0,2'b00,1'b0,5'd11,64'h99,          1'b0,1'b0,1'b0,5'd11,64'h99);

        #3;
        chk("reset_RegWrite", {63'd0, RegWrite}, 64'd0);
        chk("reset_w_reg", {59'd0, w_reg}, 64'd0);
        chk("reset_w_data", w_data, 64'd0);
        chk("reset_retired", {32'd0, retired}, 64'd0);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) apply(tbl[i], $sformatf("vec%0d", i));

        // Stall holds the register for three cycles; stall plus flush kills the write.
        apply(mk(1'b1,1'b1,1'b0,2'b00,1'b0,5'd12,64'hCAFE,1'b0,1'b0,1'b1,5'd12,64'hCAFE), "pre_stall");
        for (int i = 0; i < 3; i++)
            apply(mk(1'b1,1'b1,1'b0,2'b00,1'b0,5'd13,64'hBEEF,1'b1,1'b0,1'b1,5'd12,64'hCAFE), "stall");
        apply(mk(1'b1,1'b1,1'b0,2'b00,1'b0,5'd13,64'hBEEF,1'b1,1'b1,1'b0,5'd12,64'hCAFE), "stall_flush");
        apply(mk(1'b1,1'b1,1'b0,2'b00,1'b0,5'd14,64'h77,  1'b0,1'b1,1'b0,5'd14,64'h77), "flush");
        apply(mk(1'b1,1'b1,1'b0,2'b00,1'b0,5'd14,64'h77,  1'b0,1'b0,1'b1,5'd14,64'h77), "post_flush");

`ifdef WB_BYPASS_EN
        apply(mk(1'b1,1'b1,1'b0,2'b00,1'b0,5'd7,64'hAA,1'b0,1'b0,1'b1,5'd7,64'hAA), "byp_wr");
        r_reg2 = 5'd7; r_data2 = 64'h11; r_reg1 = 5'd3; r_data1 = 64'h22;
        #1;
        chk("byp_hit2", {63'd0, byp_hit2}, 64'd1);
        chk("byp_data2", byp_data2, 64'hAA);
        chk("byp_hit1_miss", {63'd0, byp_hit1}, 64'd0);
        chk("byp_data1_miss", byp_data1, 64'h22);
        apply(mk(1'b1,1'b1,1'b0,2'b00,1'b0,5'd31,64'hBB,1'b0,1'b0,1'b0,5'd31,64'hBB), "byp_xzr");
        r_reg1 = 5'd31; r_data1 = 64'h33;
        #1;
        chk("byp_hit1_xzr", {63'd0, byp_hit1}, 64'd0);
        chk("byp_data1_xzr", byp_data1, 64'h33);
`endif

        // Reset asserted mid-cycle while a write is active.
        apply(mk(1'b1,1'b1,1'b0,2'b00,1'b0,5'd20,64'hD00D,1'b0,1'b0,1'b1,5'd20,64'hD00D), "pre_rst");
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_RegWrite", {63'd0, RegWrite}, 64'd0);
        chk("midrst_w_data", w_data, 64'd0);
        chk("midrst_retired", {32'd0, retired}, 64'd0);
        model_ret = 32'd0;
        #1 rst_n = 1'b1;
        apply(mk(1'b0,1'b0,1'b0,2'b00,1'b0,5'd0,64'h0,1'b0,1'b0,1'b0,5'd0,64'h0), "post_rst");
        apply(mk(1'b1,1'b1,1'b0,2'b00,1'b0,5'd21,64'h4242,1'b0,1'b0,1'b1,5'd21,64'h4242), "post_rst_wr");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

MEM/WB pipeline register and write-back stage of the LEGv8 core. Captures the MEM-stage result, sizes and extends load data, and drives the write port of the ID-stage register file (`w_reg`, `w_data`, `RegWrite`). Writes to X31 (XZR) are suppressed, and retired instructions are counted. An optional bypass resolves the same-cycle write/read hazard for the two ID read ports.

## Interface
- `WORD_W`, default `` `WORD `` (64), datapath width in bits.
- `CNT_W`, default 32, width of the retire counter.

Ports:
- `clk` in 1: core clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `m_valid` in 1: the MEM stage holds a real instruction.
- `m_RegWrite` in 1: the instruction writes `m_rd`.
- `m_MemtoReg` in 1: 1 selects load data, 0 selects the ALU result.
- `m_size` in 2: load size. 00 = byte, 01 = half, 10 = word, 11 = double.
- `m_signed` in 1: sign-extend load data (LDURSW/LDURSH/LDURSB).
- `m_rd` in 5: destination register.
- `m_alu_res` in WORD_W: ALU result.
- `m_mem_rdata` in WORD_W: raw data-memory read data, little-endian, right-aligned.
- `stall` in 1: hold the MEM/WB register.
- `flush` in 1: invalidate the incoming instruction.
- `w_reg` out 5: register-file write address.
- `w_data` out WORD_W: register-file write data.
- `RegWrite` out 1: register-file write enable.
- `retired` out CNT_W: count of valid instructions captured.
- `r_reg1`, `r_reg2` in 5 each: ID read addresses. Only present with `WB_BYPASS_EN`.
- `byp_data1`, `byp_data2` out WORD_W each: bypassed read data. Only present with `WB_BYPASS_EN`.
- `byp_hit1`, `byp_hit2` out 1 each: bypass is active on that port. Only present with `WB_BYPASS_EN`.
- External `r_data1`/`r_data2` from the register file are also inputs to the bypass mux.

## Operation
- The state is a single MEM/WB register: `wb_valid`, `wb_we`, `wb_rd`, `wb_data`.
- Capture happens on a rising edge when `stall`=0.
  - `wb_valid` ← `m_valid & ~flush`
  - `wb_we` ← `m_RegWrite`
  - `wb_rd` ← `m_rd`
  - `wb_data` ← the selected result
- Result selection is done before capture:
  - `m_MemtoReg`=0: the result is `m_alu_res`.
  - `m_MemtoReg`=1: the result is the low 8/16/32/64 bits of `m_mem_rdata`, per `m_size`.
  - The selected field is zero-extended, or sign-extended from its MSB when `m_signed`=1.
  - For `m_size`=11, `m_signed` is ignored.
- When `stall`=1, the register holds. Outputs stay asserted, and rewriting the same data is idempotent.
- `flush` takes priority over `stall`: `wb_valid` is cleared even while stalled.
- Outputs:
  - `w_reg` = `wb_rd`
  - `w_data` = `wb_data`
  - `RegWrite` = `wb_valid & wb_we & (wb_rd != 31)`
- `retired` increments on every capture edge where `m_valid & ~flush & ~stall`. It wraps modulo 2^CNT_W.

## Timing
- All outputs are registered state or combinational functions of registered state. There are no combinational paths from `m_*` to the outputs.
- Latency: an instruction presented at edge N drives `RegWrite` during cycle N→N+1. The register file commits it at edge N+1.
- The bypass is combinational from `r_reg*` and the WB register. It is valid in the same cycle.
- Asynchronous reset clears:
  - `wb_valid`, `wb_we`, `wb_rd`, `wb_data` to 0
  - `RegWrite`=0, `w_reg`=0, `w_data`=0
  - `retired`=0
  - `byp_hit*`=0, `byp_data*` = `r_data*`
- Reset mid-write: `RegWrite` drops immediately (asynchronously), so no write occurs.

## Configuration
- `WB_BYPASS_EN` defined:
  - The bypass ports exist.
  - `byp_hitK` = `RegWrite & (r_regK == wb_rd)`.
  - `byp_dataK` = `byp_hitK ? wb_data : r_dataK`.
  - X31 is never bypassed.
- `WB_BYPASS_EN` undefined:
  - The bypass ports and logic are removed.
  - ID reads the register file directly.
  - Hazards are then resolved by the hazard unit stalling one extra cycle.

## Test plan
- **Reset:** assert `rst_n`=0 mid-cycle with `RegWrite` active → `RegWrite`=0 immediately. After release, `retired`=0 and `w_data`=0.
- **ALU write-back:**
  - Stimulus: `m_valid`=1, `m_RegWrite`=1, `m_MemtoReg`=0, `m_rd`=5, `m_alu_res`=0x1234.
  - Response: on the next cycle, `RegWrite`=1, `w_reg`=5, `w_data`=0x1234, `retired`=1.
- **Load extension:** `m_MemtoReg`=1, `m_mem_rdata`=0xFFFF_FFFF_8000_0080.
  - size 00, unsigned → 0x80.
  - size 00, signed → 0xFFFF_FFFF_FFFF_FF80.
  - size 10, signed → 0xFFFF_FFFF_8000_0080.
  - size 01, unsigned → 0x0080.
- **XZR:** `m_rd`=31, `m_RegWrite`=1 → `RegWrite` stays 0. With the bypass enabled, `r_reg1`=31 gives `byp_hit1`=0.
- **Stall/flush:**
  - `stall`=1 for 3 cycles → WB outputs hold and `retired` is unchanged.
  - `stall`=1 with `flush`=1 → `RegWrite`=0 on the next cycle.
- **Bypass (`WB_BYPASS_EN`):**
  - Stimulus: WB writing X7=0xAA while `r_reg2`=7 and `r_data2`=0x11.
  - Response: `byp_hit2`=1, `byp_data2`=0xAA.
  - With the macro undefined, the build has no bypass ports.
